cs_window_filter: RTL and testbench

Parametrised sliding-window "approximate average" filter for streaming sensor samples. Keeps the last DEPTH samples and a running sum. Per accepted sample it produces the floor average, the approximate average (the largest window element not above the average) and a scaled output Y. Adds a valid handshake, warm-up suppression, flush, a selectable output mode and saturation.

---
 rtl/cs_window_filter.sv | 146 ++++++++++++++
 tb/tb_cs_window_filter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cs_window_filter.sv
// Sliding-window approximate-average filter.
// A DEPTH-sample window plus running sum feeds a two-stage pipeline:
// stage A derives the floor average and the approximate average, and
// stage B forms the scaled, saturated Y. Results appear 2 cycles after accept.
module cs_window_filter #(
  parameter int DW    = 8,
  parameter int DEPTH = 9,
  parameter int SHIFT = 3,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] X,
  input  logic          flush,
  input  logic          mode,
  output logic          out_valid,
  output logic [YW-1:0] Y,
  output logic [DW-1:0] appr,
  output logic [DW-1:0] avg
);

  localparam int SW = DW + $clog2(DEPTH);      // running sum width
  localparam int FW = $clog2(DEPTH + 1);       // fill counter width
  localparam int NW = SW + 1;                  // SUM + DEPTH*value < 2*DEPTH*2^DW
  localparam int CW = ((NW > YW) ? NW : YW) + 1;
  localparam logic [CW-1:0] YMAX = {{(CW-YW){1'b0}}, {YW{1'b1}}};

  // window storage and accept stage
  logic [DEPTH-1:0][DW-1:0] win_q, win_d;
  logic [SW-1:0]            sum_q, sum_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic                     mode_q;
  logic [1:0]               vld_q;             // [0]: accept stage, [1]: stage A
  logic                     accept;

  // stage A registers
  logic [DW-1:0] avg_a_q, appr_a_q;
  logic [SW-1:0] sum_a_q;
  logic          mode_a_q;
  logic [DW-1:0] avg_c, appr_c;

  // stage B registers / combinational result
  logic          out_valid_q;
  logic [YW-1:0] y_q, y_d;
  logic [DW-1:0] appr_q, avg_q;
  logic [DW-1:0] sel_c;
  logic [NW-1:0] n_c, nsh_c;

  // flush always wins over a sample presented in the same cycle
  assign accept = in_valid & ~flush;

  // next window: shift toward entry 0 (oldest), new sample in the top slot
  always_comb begin
    win_d  = win_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (accept) begin
      for (int i = 0; i < DEPTH-1; i++) win_d[i] = win_q[i+1];
      win_d[DEPTH-1] = X;
      sum_d = sum_q + SW'(X) - SW'(win_q[0]);
      if (fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
    end
  end

  // window, sum, fill counter, captured mode and valid pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q  <= '0;
      sum_q  <= '0;
      fill_q <= '0;
      mode_q <= 1'b0;
      vld_q  <= '0;
    end else if (flush) begin
      win_q  <= '0;
      sum_q  <= '0;
      fill_q <= '0;
      vld_q  <= '0;
    end else begin
      win_q    <= win_d;
      sum_q    <= sum_d;
      fill_q   <= fill_d;
      if (accept) mode_q <= mode;
      vld_q[0] <= accept && (fill_d == FW'(DEPTH));
      vld_q[1] <= vld_q[0];
    end
  end

  // floor average and largest window entry not above it; min <= floor(mean)
  // guarantees a candidate exists, so starting the search at 0 is safe
  always_comb begin
    avg_c  = DW'(sum_q / SW'(DEPTH));
    appr_c = '0;
    for (int i = 0; i < DEPTH; i++)
      if (win_q[i] <= avg_c && win_q[i] > appr_c) appr_c = win_q[i];
  end

  // stage A: register average, approximate average and forwarded context
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avg_a_q  <= '0;
      appr_a_q <= '0;
      sum_a_q  <= '0;
      mode_a_q <= 1'b0;
    end else begin
      avg_a_q  <= avg_c;
      appr_a_q <= appr_c;
      sum_a_q  <= sum_q;
      mode_a_q <= mode_q;
    end
  end

  // Y numerator, shift and saturation
  always_comb begin
    sel_c = mode_a_q ? avg_a_q : appr_a_q;
    n_c   = NW'(sum_a_q) + NW'(DEPTH) * NW'(sel_c);
    nsh_c = n_c >> SHIFT;
    if (CW'(nsh_c) > YMAX) y_d = '1;
    else                   y_d = YW'(nsh_c);
  end

  // stage B: outputs update only on a valid result, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      appr_q      <= '0;
      avg_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld_q[1];
      if (vld_q[1]) begin
        y_q    <= y_d;
        appr_q <= appr_a_q;
        avg_q  <= avg_a_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign appr      = appr_q;
  assign avg       = avg_q;

endmodule

// File: tb/tb_cs_window_filter.sv
// Bench for cs_window_filter: directed scenarios plus random traffic checked
// against a queue-based window model with a two-cycle result delay.
module tb_cs_window_filter;
  localparam int DW = 8, DEPTH = 9, SHIFT = 3, YW = 10, YW9 = 9;

  logic          clk = 1'b0;
  logic          reset, in_valid, flush, mode;
  logic [DW-1:0] X;
  logic          out_valid, out_valid2;
  logic [YW-1:0] Y;
  logic [YW9-1:0] Y9;
  logic [DW-1:0] appr, avg, appr2, avg2;

  always #5 clk = ~clk;

  cs_window_filter #(.DW(DW), .DEPTH(DEPTH), .SHIFT(SHIFT), .YW(YW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X), .flush(flush), .mode(mode),
    .out_valid(out_valid), .Y(Y), .appr(appr), .avg(avg));

  cs_window_filter #(.DW(DW), .DEPTH(DEPTH), .SHIFT(SHIFT), .YW(YW9)) dut9 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X), .flush(flush), .mode(mode),
    .out_valid(out_valid2), .Y(Y9), .appr(appr2), .avg(avg2));

  typedef struct { bit v; int y; int y9; int ap; int av; } res_t;

  int   mq[$];
  int   mfill;
  res_t p0, p1;
  bit   ex_ov;
  int   ex_y, ex_y9, ex_ap, ex_av;
  int   ncmp = 0, nfail = 0;

  logic [52:0] act_v, exp_v;
  assign act_v = {out_valid, Y, Y9, appr, avg, out_valid2, appr2, avg2};
  assign exp_v = {ex_ov, ex_y[9:0], ex_y9[8:0], ex_ap[7:0], ex_av[7:0],
                  ex_ov, ex_ap[7:0], ex_av[7:0]};

  task automatic clear_window();
    mq.delete();
    repeat (DEPTH) mq.push_back(0);
    mfill = 0;
  endtask

  task automatic model_reset();
    clear_window();
    p0 = '{default: 0};
    p1 = '{default: 0};
    ex_ov = 0; ex_y = 0; ex_y9 = 0; ex_ap = 0; ex_av = 0;
  endtask

  // results straight from the window contents
  task automatic calc(input bit m, output res_t r);
    int s, av, ap, n, y;
    s = 0; ap = 0;
    foreach (mq[i]) s += mq[i];
    av = s / DEPTH;
    foreach (mq[i]) if (mq[i] <= av && mq[i] > ap) ap = mq[i];
    n = s + DEPTH * (m ? av : ap);
    y = n >> SHIFT;
    r.v  = 1;
    r.y  = (y > (1 << YW) - 1)  ? (1 << YW) - 1  : y;
    r.y9 = (y > (1 << YW9) - 1) ? (1 << YW9) - 1 : y;
    r.ap = ap;
    r.av = av;
  endtask

  task automatic model_edge(input bit v, input int x, input bit f, input bit m);
    if (f) begin
      clear_window();
      p0.v = 0; p1.v = 0; ex_ov = 0;
      return;
    end
    ex_ov = p1.v;
    if (p1.v) begin ex_y = p1.y; ex_y9 = p1.y9; ex_ap = p1.ap; ex_av = p1.av; end
    p1 = p0;
    p0.v = 0;
    if (v) begin
      void'(mq.pop_front());
      mq.push_back(x);
      if (mfill < DEPTH) mfill++;
      if (mfill == DEPTH) calc(m, p0);
    end
  endtask

  task automatic tick(input bit v, input int x, input bit f, input bit m);
    @(negedge clk);
    in_valid = v; X = DW'(x); flush = f; mode = m;
    @(posedge clk);
    model_edge(v, x, f, m);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; X = 0; flush = 0; mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    ncmp++;
    if (act_v !== exp_v) begin nfail++; $display("FAIL reset: got %h want %h", act_v, exp_v); end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_warmup();
    int pulses = 0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      tick(i <= DEPTH, i, 0, 0);
      ncmp++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL warmup cyc %0d: got %h want %h", i, act_v, exp_v); end
      if (i <= DEPTH + 1 && out_valid) pulses++;
    end
    ncmp++;
    if (pulses != 0) begin nfail++; $display("FAIL warmup_early_pulse: got %0d want 0", pulses); end
    ncmp++;
    if (!(out_valid === 1'b1 && avg === 8'd5 && appr === 8'd5 && Y === 10'd11)) begin
      nfail++; $display("FAIL warmup_first: ov=%b avg=%0d appr=%0d Y=%0d want 1/5/5/11", out_valid, avg, appr, Y);
    end
  endtask

  task automatic test_mode();
    int vals[9] = '{2, 2, 2, 2, 2, 9, 9, 9, 9};
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        tick(i < DEPTH, (i < DEPTH) ? vals[i] : 0, 0, m[0]);
        ncmp++;
        if (act_v !== exp_v) begin nfail++; $display("FAIL mode%0d cyc %0d: got %h want %h", m, i, act_v, exp_v); end
      end
      ncmp++;
      if (!(out_valid === 1'b1 && avg === 8'd5 && appr === 8'd2 && Y === (m ? 10'd11 : 10'd8))) begin
        nfail++; $display("FAIL mode%0d_result: ov=%b avg=%0d appr=%0d Y=%0d", m, out_valid, avg, appr, Y);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick(i < DEPTH, 255, 0, 0);
      ncmp++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL sat cyc %0d: got %h want %h", i, act_v, exp_v); end
    end
    ncmp++;
    if (!(out_valid === 1'b1 && avg === 8'd255 && appr === 8'd255 && Y === 10'd573 && Y9 === 9'd511)) begin
      nfail++; $display("FAIL sat_result: avg=%0d appr=%0d Y=%0d Y9=%0d want 255/255/573/511", avg, appr, Y, Y9);
    end
  endtask

  task automatic test_gaps();
    bit pat[7] = '{1, 0, 0, 1, 0, 0, 0};
    bit want[7] = '{0, 0, 1, 0, 0, 1, 0};
    logic [YW-1:0] yh;
    for (int i = 0; i < 7; i++) begin
      tick(pat[i], $urandom_range(0, 255), 0, $urandom_range(0, 1));
      ncmp++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL gaps cyc %0d: got %h want %h", i, act_v, exp_v); end
      ncmp++;
      if (out_valid !== want[i]) begin nfail++; $display("FAIL gaps_pulse cyc %0d: got %b want %b", i, out_valid, want[i]); end
      if (i == 2) yh = Y;
      if (i == 4) begin
        ncmp++;
        if (Y !== yh) begin nfail++; $display("FAIL gaps_hold: got %0d want %0d", Y, yh); end
      end
    end
  endtask

  task automatic test_flush();
    logic [YW-1:0] yh;
    logic [DW-1:0] ah, vh;
    int pulses = 0;
    for (int i = 0; i < 4; i++) tick(1, $urandom_range(0, 255), 0, 0);
    yh = Y; ah = appr; vh = avg;
    tick(1, 77, 1, 0);
    ncmp++;
    if (act_v !== exp_v) begin nfail++; $display("FAIL flush_edge: got %h want %h", act_v, exp_v); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      tick(i < DEPTH - 1, $urandom_range(0, 255), 0, $urandom_range(0, 1));
      ncmp++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL flush cyc %0d: got %h want %h", i, act_v, exp_v); end
      if (out_valid) pulses++;
    end
    ncmp++;
    if (pulses != 0 || Y !== yh || appr !== ah || avg !== vh) begin
      nfail++; $display("FAIL flush_hold: pulses=%0d Y=%0d/%0d appr=%0d/%0d avg=%0d/%0d", pulses, Y, yh, appr, ah, avg, vh);
    end
    tick(1, $urandom_range(0, 255), 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    ncmp++;
    if (out_valid !== 1'b1 || act_v !== exp_v) begin nfail++; $display("FAIL flush_refill: got %h want %h", act_v, exp_v); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 reset = 1;
    model_reset();
    #1;
    ncmp++;
    if (act_v !== exp_v) begin nfail++; $display("FAIL async_reset: got %h want %h", act_v, exp_v); end
    @(negedge clk); reset = 0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      tick(i <= DEPTH, 10 * i, 0, 0);
      ncmp++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL post_reset cyc %0d: got %h want %h", i, act_v, exp_v); end
    end
    ncmp++;
    if (!(out_valid === 1'b1 && avg === 8'd50 && appr === 8'd50 && Y === 10'd112)) begin
      nfail++; $display("FAIL post_reset_result: ov=%b avg=%0d appr=%0d Y=%0d want 1/50/50/112", out_valid, avg, appr, Y);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 49) == 0, $urandom_range(0, 1));
      ncmp++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL random cyc %0d: got %h want %h", i, act_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_mode();
    test_saturation();
    test_gaps();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
